reservation_station: RTL and testbench

Arithmetic reservation station feeding the ALU in the Tomasulo core. Accepts decoded non-memory instructions from the dispatcher and holds them until both operands are known. Captures operands from the ALU and LSB common-data-bus broadcasts. Issues one ready instruction per cycle to the ALU through registered outputs.

---
 rtl/reservation_station_pkg.sv | 47 ++++
 rtl/reservation_station_select.sv | 35 +++
 rtl/reservation_station.sv | 152 +++++++++++++++
 tb/tb_reservation_station.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types, opcode encodings and tag helpers
// for the ALU reservation station.
package reservation_station_pkg;

  localparam int ROB_W       = 4;
  localparam int OP_W        = 6;
  localparam int RS_SIZE_DEF = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [ROB_W-1:0] rob_tag_t;
  typedef logic [OP_W-1:0]  op_t;

  localparam op_t OP_NOP  = 6'd0;
  localparam op_t OP_ADD  = 6'd1;
  localparam op_t OP_SUB  = 6'd2;
  localparam op_t OP_AND  = 6'd3;
  localparam op_t OP_OR   = 6'd4;
  localparam op_t OP_XOR  = 6'd5;
  localparam op_t OP_SLL  = 6'd6;
  localparam op_t OP_SRL  = 6'd7;
  localparam op_t OP_ADDI = 6'd8;

  typedef struct packed {
    op_t         op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        qj_busy;
    logic        qk_busy;
    rob_tag_t    qj;
    rob_tag_t    qk;
    logic [31:0] imm;
    logic [31:0] pc;
    rob_tag_t    rd_tag;
  } rs_entry_t;

  function automatic logic tag_hit(
    input logic     pend,
    input logic     en,
    input rob_tag_t q,
    input rob_tag_t t
  );
    return pend & en & (q == t);
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index free and ready entry pickers
// for the reservation station.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic [RS_SIZE-1:0]  busy,
  input  logic [RS_SIZE-1:0]  ready,
  output logic [RS_IDX_W-1:0] free_idx,
  output logic                free_found,
  output logic [RS_IDX_W-1:0] ready_idx,
  output logic                ready_found
);

  // Walk high to low so the last hit is the lowest index.
  always_comb begin
    free_idx    = '0;
    free_found  = FALSE;
    ready_idx   = '0;
    ready_found = FALSE;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = RS_IDX_W'(i);
        free_found = TRUE;
      end
      if (ready[i]) begin
        ready_idx   = RS_IDX_W'(i);
        ready_found = TRUE;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until
// operands arrive on the CDBs, then issues one per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        issue_valid,
  input  op_t         issue_op,
  input  logic [31:0] issue_Vj,
  input  logic [31:0] issue_Vk,
  input  logic        issue_Qj_busy,
  input  logic        issue_Qk_busy,
  input  rob_tag_t    issue_Qj,
  input  rob_tag_t    issue_Qk,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_pc,
  input  rob_tag_t    issue_rdTag,
  input  logic        alu_bus_enable,
  input  logic [31:0] alu_bus_result,
  input  rob_tag_t    alu_bus_rdTag,
  input  logic        lsb_bus_enable,
  input  logic [31:0] lsb_bus_result,
  input  rob_tag_t    lsb_bus_rdTag,
  output logic        rs_full,
  output logic        RS_valid,
  output op_t         RS_op,
  output logic [31:0] RS_Vj,
  output logic [31:0] RS_Vk,
  output logic [31:0] RS_imm,
  output logic [31:0] RS_pc,
  output rob_tag_t    RS_rdTag
);

  rs_entry_t             ent [RS_SIZE];
  logic [RS_SIZE-1:0]    busy;
  logic [RS_SIZE-1:0]    ready;
  logic [RS_IDX_W-1:0]   free_idx;
  logic [RS_IDX_W-1:0]   ready_idx;
  logic                  free_found;
  logic                  ready_found;
  logic                  do_issue;
  rs_entry_t             new_ent;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++)
      ready[i] = busy[i] & ~ent[i].qj_busy & ~ent[i].qk_busy;
  end

  rs_select #(
    .RS_SIZE  (RS_SIZE),
    .RS_IDX_W (RS_IDX_W)
  ) u_sel (
    .busy        (busy),
    .ready       (ready),
    .free_idx    (free_idx),
    .free_found  (free_found),
    .ready_idx   (ready_idx),
    .ready_found (ready_found)
  );

  assign rs_full  = &busy;
  assign do_issue = issue_valid & (issue_op != OP_NOP) & free_found;

  // Incoming entry, with same-edge CDB forwarding; ALU bus wins.
  always_comb begin
    new_ent.op      = issue_op;
    new_ent.vj      = issue_Vj;
    new_ent.vk      = issue_Vk;
    new_ent.qj_busy = issue_Qj_busy;
    new_ent.qk_busy = issue_Qk_busy;
    new_ent.qj      = issue_Qj;
    new_ent.qk      = issue_Qk;
    new_ent.imm     = issue_imm;
    new_ent.pc      = issue_pc;
    new_ent.rd_tag  = issue_rdTag;
    if (tag_hit(issue_Qj_busy, alu_bus_enable, issue_Qj, alu_bus_rdTag)) begin
      new_ent.vj      = alu_bus_result;
      new_ent.qj_busy = FALSE;
    end else if (tag_hit(issue_Qj_busy, lsb_bus_enable, issue_Qj, lsb_bus_rdTag)) begin
      new_ent.vj      = lsb_bus_result;
      new_ent.qj_busy = FALSE;
    end
    if (tag_hit(issue_Qk_busy, alu_bus_enable, issue_Qk, alu_bus_rdTag)) begin
      new_ent.vk      = alu_bus_result;
      new_ent.qk_busy = FALSE;
    end else if (tag_hit(issue_Qk_busy, lsb_bus_enable, issue_Qk, lsb_bus_rdTag)) begin
      new_ent.vk      = lsb_bus_result;
      new_ent.qk_busy = FALSE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      RS_valid <= FALSE;
      RS_op    <= OP_NOP;
      RS_Vj    <= '0;
      RS_Vk    <= '0;
      RS_imm   <= '0;
      RS_pc    <= '0;
      RS_rdTag <= '0;
      for (int i = 0; i < RS_SIZE; i++)
        ent[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy     <= '0;
        RS_valid <= FALSE;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            if (tag_hit(ent[i].qj_busy, alu_bus_enable, ent[i].qj, alu_bus_rdTag)) begin
              ent[i].vj      <= alu_bus_result;
              ent[i].qj_busy <= FALSE;
            end else if (tag_hit(ent[i].qj_busy, lsb_bus_enable, ent[i].qj, lsb_bus_rdTag)) begin
              ent[i].vj      <= lsb_bus_result;
              ent[i].qj_busy <= FALSE;
            end
            if (tag_hit(ent[i].qk_busy, alu_bus_enable, ent[i].qk, alu_bus_rdTag)) begin
              ent[i].vk      <= alu_bus_result;
              ent[i].qk_busy <= FALSE;
            end else if (tag_hit(ent[i].qk_busy, lsb_bus_enable, ent[i].qk, lsb_bus_rdTag)) begin
              ent[i].vk      <= lsb_bus_result;
              ent[i].qk_busy <= FALSE;
            end
          end
        end
        RS_valid <= ready_found;
        if (ready_found) begin
          RS_op           <= ent[ready_idx].op;
          RS_Vj           <= ent[ready_idx].vj;
          RS_Vk           <= ent[ready_idx].vk;
          RS_imm          <= ent[ready_idx].imm;
          RS_pc           <= ent[ready_idx].pc;
          RS_rdTag        <= ent[ready_idx].rd_tag;
          busy[ready_idx] <= FALSE;
        end
        if (do_issue) begin
          ent[free_idx]  <= new_ent;
          busy[free_idx] <= TRUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed scenarios plus random traffic
// against a slot-list reference model of the station.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, issue_valid;
  op_t         issue_op;
  logic [31:0] issue_Vj, issue_Vk, issue_imm, issue_pc;
  logic        issue_Qj_busy, issue_Qk_busy;
  rob_tag_t    issue_Qj, issue_Qk, issue_rdTag;
  logic        alu_bus_enable, lsb_bus_enable;
  logic [31:0] alu_bus_result, lsb_bus_result;
  rob_tag_t    alu_bus_rdTag, lsb_bus_rdTag;
  logic        rs_full, RS_valid;
  op_t         RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_imm, RS_pc;
  rob_tag_t    RS_rdTag;

  reservation_station #(.RS_SIZE(N), .RS_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj_busy(issue_Qj_busy), .issue_Qk_busy(issue_Qk_busy),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rdTag(issue_rdTag),
    .alu_bus_enable(alu_bus_enable), .alu_bus_result(alu_bus_result),
    .alu_bus_rdTag(alu_bus_rdTag),
    .lsb_bus_enable(lsb_bus_enable), .lsb_bus_result(lsb_bus_result),
    .lsb_bus_rdTag(lsb_bus_rdTag),
    .rs_full(rs_full), .RS_valid(RS_valid), .RS_op(RS_op),
    .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_imm(RS_imm), .RS_pc(RS_pc),
    .RS_rdTag(RS_rdTag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    op_t         op;
    logic [31:0] vj, vk, imm, pc;
    bit          wj, wk;
    rob_tag_t    qj, qk, rd;
  } slot_t;

  slot_t       m [N];
  bit          mo_valid;
  op_t         mo_op;
  logic [31:0] mo_vj, mo_vk, mo_imm, mo_pc;
  rob_tag_t    mo_rd;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m[i].busy);
    return c;
  endfunction

  function automatic bit hit(bit w, rob_tag_t q, bit en, rob_tag_t t);
    return w && en && (q == t);
  endfunction

  // Reference behaviour for one rising edge, from current inputs.
  task automatic model_step();
    int    sel, fr;
    slot_t s;
    if (!rst) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      mo_valid = 0; mo_op = OP_NOP; mo_vj = 0; mo_vk = 0;
      mo_imm = 0; mo_pc = 0; mo_rd = 0;
      return;
    end
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      mo_valid = 0;
      return;
    end
    sel = -1;
    fr = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && !m[i].wj && !m[i].wk) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      if (hit(m[i].wj, m[i].qj, alu_bus_enable, alu_bus_rdTag)) begin
        m[i].vj = alu_bus_result; m[i].wj = 0;
      end else if (hit(m[i].wj, m[i].qj, lsb_bus_enable, lsb_bus_rdTag)) begin
        m[i].vj = lsb_bus_result; m[i].wj = 0;
      end
      if (hit(m[i].wk, m[i].qk, alu_bus_enable, alu_bus_rdTag)) begin
        m[i].vk = alu_bus_result; m[i].wk = 0;
      end else if (hit(m[i].wk, m[i].qk, lsb_bus_enable, lsb_bus_rdTag)) begin
        m[i].vk = lsb_bus_result; m[i].wk = 0;
      end
    end
    if (sel >= 0) begin
      mo_valid = 1; mo_op = m[sel].op; mo_vj = m[sel].vj; mo_vk = m[sel].vk;
      mo_imm = m[sel].imm; mo_pc = m[sel].pc; mo_rd = m[sel].rd;
      m[sel].busy = 0;
    end else begin
      mo_valid = 0;
    end
    if (issue_valid && issue_op != OP_NOP && fr >= 0) begin
      s.busy = 1; s.op = issue_op; s.vj = issue_Vj; s.vk = issue_Vk;
      s.imm = issue_imm; s.pc = issue_pc; s.rd = issue_rdTag;
      s.wj = issue_Qj_busy; s.qj = issue_Qj;
      s.wk = issue_Qk_busy; s.qk = issue_Qk;
      if (hit(s.wj, s.qj, alu_bus_enable, alu_bus_rdTag)) begin
        s.vj = alu_bus_result; s.wj = 0;
      end else if (hit(s.wj, s.qj, lsb_bus_enable, lsb_bus_rdTag)) begin
        s.vj = lsb_bus_result; s.wj = 0;
      end
      if (hit(s.wk, s.qk, alu_bus_enable, alu_bus_rdTag)) begin
        s.vk = alu_bus_result; s.wk = 0;
      end else if (hit(s.wk, s.qk, lsb_bus_enable, lsb_bus_rdTag)) begin
        s.vk = lsb_bus_result; s.wk = 0;
      end
      m[fr] = s;
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("RS_valid", 32'(RS_valid), 32'(mo_valid));
    chk("RS_op", 32'(RS_op), 32'(mo_op));
    chk("RS_Vj", RS_Vj, mo_vj);
    chk("RS_Vk", RS_Vk, mo_vk);
    chk("RS_imm", RS_imm, mo_imm);
    chk("RS_pc", RS_pc, mo_pc);
    chk("RS_rdTag", 32'(RS_rdTag), 32'(mo_rd));
    chk("rs_full", 32'(rs_full), 32'(m_count() == N));
  end

  always @(posedge clk)
    if (rst && rdy && !clear && issue_valid && issue_op != OP_NOP)
      assert (!rs_full) else $error("issue presented while rs_full");

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 1; rdy = 1; clear = 0; issue_valid = 0;
    alu_bus_enable = 0; lsb_bus_enable = 0;
  endtask

  task automatic put(input op_t op, input logic [31:0] vj, input logic [31:0] vk,
                     input bit jb, input rob_tag_t qj,
                     input bit kb, input rob_tag_t qk, input rob_tag_t rd);
    issue_valid = 1; issue_op = op; issue_Vj = vj; issue_Vk = vk;
    issue_Qj_busy = jb; issue_Qj = qj; issue_Qk_busy = kb; issue_Qk = qk;
    issue_rdTag = rd; issue_imm = 32'h100 + 32'(rd);
    issue_pc = 32'h8000_0000 + 32'(rd) * 4;
  endtask

  task automatic alu(input rob_tag_t t, input logic [31:0] v);
    alu_bus_enable = 1; alu_bus_rdTag = t; alu_bus_result = v;
  endtask

  initial begin
    idle();
    rst = 0;
    put(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
    issue_valid = 0;
    alu_bus_result = 0; alu_bus_rdTag = 0;
    lsb_bus_result = 0; lsb_bus_rdTag = 0;
    step();
    chk_en = 1;
    chk("reset_valid", 32'(RS_valid), 0);
    chk("reset_op", 32'(RS_op), 32'(OP_NOP));
    chk("reset_full", 32'(rs_full), 0);
    chk("reset_pc", RS_pc, 0);
    idle();

    // ready issue
    put(OP_ADD, 5, 7, 0, 0, 0, 0, 3);
    step(); idle(); step();
    chk("ready_valid", 32'(RS_valid), 1);
    chk("ready_op", 32'(RS_op), 32'(OP_ADD));
    chk("ready_vj", RS_Vj, 5);
    chk("ready_vk", RS_Vk, 7);
    chk("ready_tag", 32'(RS_rdTag), 3);
    step();
    chk("ready_done", 32'(RS_valid), 0);

    // wake-up from ALU bus
    put(OP_SUB, 0, 1, 1, 2, 0, 0, 4);
    step(); idle(); step();
    chk("wake_wait", 32'(RS_valid), 0);
    alu(2, 32'h10);
    step(); idle();
    chk("wake_notyet", 32'(RS_valid), 0);
    step();
    chk("wake_valid", 32'(RS_valid), 1);
    chk("wake_vj", RS_Vj, 32'h10);
    chk("wake_tag", 32'(RS_rdTag), 4);
    step();

    // same-edge forward from LSB bus
    put(OP_OR, 3, 0, 0, 0, 1, 6, 5);
    lsb_bus_enable = 1; lsb_bus_rdTag = 6; lsb_bus_result = 32'hABCD;
    step(); idle(); step();
    chk("fwd_valid", 32'(RS_valid), 1);
    chk("fwd_vk", RS_Vk, 32'hABCD);

    // one broadcast wakes two entries
    put(OP_XOR, 0, 2, 1, 1, 0, 0, 8);
    step();
    put(OP_AND, 9, 0, 0, 0, 1, 1, 9);
    step(); idle();
    alu(1, 32'h55);
    step(); idle(); step();
    chk("dual_first_tag", 32'(RS_rdTag), 8);
    chk("dual_first_vj", RS_Vj, 32'h55);
    step();
    chk("dual_second_valid", 32'(RS_valid), 1);
    chk("dual_second_tag", 32'(RS_rdTag), 9);
    chk("dual_second_vk", RS_Vk, 32'h55);
    step();
    chk("dual_done", 32'(RS_valid), 0);

    // fill, drain and reuse entry 0
    for (int i = 0; i < N; i++) begin
      put(OP_ADD, 32'(i), 0, 1, 9, 0, 0, rob_tag_t'(i));
      step();
    end
    idle();
    chk("full_set", 32'(rs_full), 1);
    alu(9, 32'h99);
    step(); idle();
    chk("full_held", 32'(rs_full), 1);
    step();
    chk("drain0_tag", 32'(RS_rdTag), 0);
    chk("drain0_vj", RS_Vj, 32'h99);
    chk("full_drop", 32'(rs_full), 0);
    put(OP_ADDI, 32'h11, 32'h22, 0, 0, 0, 0, 14);
    step(); idle();
    chk("drain1_tag", 32'(RS_rdTag), 1);
    step();
    chk("reuse_tag", 32'(RS_rdTag), 14);
    chk("reuse_vj", RS_Vj, 32'h11);
    repeat (15) step();
    chk("drain_done", 32'(RS_valid), 0);

    // flush with concurrent issue
    for (int i = 0; i < 5; i++) begin
      put(OP_SUB, 32'(i), 32'(i), 1, 9, 0, 0, rob_tag_t'(i));
      step();
    end
    put(OP_ADD, 1, 2, 0, 0, 0, 0, 7);
    clear = 1;
    step(); idle();
    chk("flush_full", 32'(rs_full), 0);
    chk("flush_valid", 32'(RS_valid), 0);
    alu(9, 32'h9);
    step(); idle(); step();
    chk("flush_gone", 32'(RS_valid), 0);

    // rdy stall hides a broadcast
    put(OP_ADD, 0, 4, 1, 3, 0, 0, 6);
    step(); idle();
    rdy = 0;
    alu(3, 32'h77);
    repeat (3) step();
    chk("stall_valid", 32'(RS_valid), 0);
    idle();
    step(); step();
    chk("stall_nocapture", 32'(RS_valid), 0);
    alu(3, 32'h88);
    step(); idle(); step();
    chk("stall_wake_valid", 32'(RS_valid), 1);
    chk("stall_wake_vj", RS_Vj, 32'h88);

    // reset mid-operation
    put(OP_ADD, 1, 1, 0, 0, 0, 0, 2);
    step();
    put(OP_SUB, 0, 0, 1, 5, 0, 0, 3);
    step();
    idle();
    rst = 0;
    step(); idle();
    chk("rst_valid", 32'(RS_valid), 0);
    chk("rst_op", 32'(RS_op), 32'(OP_NOP));
    chk("rst_vj", RS_Vj, 0);
    alu(5, 32'h5);
    step(); idle(); step();
    chk("rst_gone", 32'(RS_valid), 0);

    // random traffic
    repeat (2000) begin
      rst = ($urandom_range(0, 299) != 0);
      rdy = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 49) == 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_op = op_t'($urandom_range(0, 8));
      issue_Vj = $urandom; issue_Vk = $urandom;
      issue_imm = $urandom; issue_pc = $urandom;
      issue_Qj_busy = ($urandom_range(0, 2) == 0);
      issue_Qk_busy = ($urandom_range(0, 2) == 0);
      issue_Qj = rob_tag_t'($urandom_range(0, 7));
      issue_Qk = rob_tag_t'($urandom_range(0, 7));
      issue_rdTag = rob_tag_t'($urandom);
      alu_bus_enable = ($urandom_range(0, 1) == 1);
      alu_bus_rdTag = rob_tag_t'($urandom_range(0, 7));
      alu_bus_result = $urandom;
      lsb_bus_enable = ($urandom_range(0, 1) == 1);
      lsb_bus_rdTag = alu_bus_rdTag ^ rob_tag_t'($urandom_range(1, 7));
      lsb_bus_result = $urandom;
      if (m_count() == N) issue_valid = 0;
      step();
    end
    idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
